// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_seq_pkg : shared funct3 encodings, FSM states and counter width      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mdu_seq_pkg;

    localparam int CNT_W = 7;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_iter : one shift-add (multiply) or restoring shift-subtract (divide) |
// | step on the {hi,lo} working register.  Rev 1.0                           |
// +--------------------------------------------------------------------------+
module mdu_iter #(
    parameter int W = 64
) (
    input  logic         i_is_div,
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_opnd,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    logic [W:0] w_sum;
    logic [W:0] w_rem;
    logic       w_ge;

    assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    assign w_rem = {i_hi, i_lo[W-1]};
    assign w_ge  = (w_rem >= {1'b0, i_opnd});

    // A successful subtract always leaves a remainder below the divisor, so W bits suffice.
    always_comb begin
        if (i_is_div) begin
            o_hi = w_ge ? (w_rem[W-1:0] - i_opnd) : w_rem[W-1:0];
            o_lo = {i_lo[W-2:0], w_ge};
        end else begin
            o_hi = w_sum[W:1];
            o_lo = {w_sum[0], i_lo[W-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_seq : sequential RV64 M-extension unit, one bit per cycle.           |
// | Option: define MDU_EARLY_OUT_EN for 1-cycle special cases.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      sel_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

`ifdef MDU_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_sel;
    logic                r_word, r_neg_q, r_neg_a, r_dz, r_ovf, r_mz;
    logic [XLEN-1:0]     r_hi, r_lo, r_opnd, r_src1, r_result;
    logic [XLEN-1:0]     w_hi_nxt, w_lo_nxt;

    logic                w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic                w_a_zero, w_b_zero, w_a_min, w_b_ones;
    logic                w_dz, w_ovf, w_mz, w_early;
    logic [XLEN-1:0]     w_a_w, w_b_w, w_a_mag, w_b_mag;
    logic [CNT_W-1:0]    w_cnt_init;
    logic [2*XLEN-1:0]   w_prod, w_prod_s;
    logic [XLEN-1:0]     w_q, w_r, w_q_s, w_r_s, w_raw, w_final;

    assign w_accept   = (r_state == ST_IDLE) & start_i & ~flush_i;
    assign w_a_signed = sel_i[2] ? ~sel_i[0] : (sel_i[1:0] != 2'b11);
    assign w_b_signed = sel_i[2] ? ~sel_i[0] : ~sel_i[1];
    assign w_a_neg    = w_a_signed & (word_i ? src1_i[31] : src1_i[XLEN-1]);
    assign w_b_neg    = w_b_signed & (word_i ? src2_i[31] : src2_i[XLEN-1]);

    // Word operands are extended by their own sign flag so negation yields a clean magnitude.
    assign w_a_w   = word_i ? {{(XLEN-32){w_a_neg}}, src1_i[31:0]} : src1_i;
    assign w_b_w   = word_i ? {{(XLEN-32){w_b_neg}}, src2_i[31:0]} : src2_i;
    assign w_a_mag = w_a_neg ? -w_a_w : w_a_w;
    assign w_b_mag = w_b_neg ? -w_b_w : w_b_w;

    assign w_a_zero = word_i ? (src1_i[31:0] == 32'd0) : (src1_i == '0);
    assign w_b_zero = word_i ? (src2_i[31:0] == 32'd0) : (src2_i == '0);
    assign w_a_min  = word_i ? (src1_i[31:0] == 32'h8000_0000)
                             : (src1_i == {1'b1, {(XLEN-1){1'b0}}});
    assign w_b_ones = word_i ? (&src2_i[31:0]) : (&src2_i);

    assign w_dz       = sel_i[2] & w_b_zero;
    assign w_ovf      = sel_i[2] & ~sel_i[0] & w_a_min & w_b_ones;
    assign w_mz       = ~sel_i[2] & (w_a_zero | w_b_zero);
    assign w_early    = EARLY_OUT & (w_dz | w_ovf | w_mz);
    assign w_cnt_init = w_early ? CNT_W'(1) : (word_i ? CNT_W'(32) : CNT_W'(64));

    mdu_iter #(.W(XLEN)) u_iter (
        .i_is_div (r_sel[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_hi_nxt),
        .o_lo     (w_lo_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CALC;
                    busy_o      = 1'b1;
                end
            end
            ST_CALC: begin
                busy_o = 1'b1;
                if (flush_i)
                    w_state_nxt = ST_IDLE;
                else if (r_cnt == CNT_W'(1))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                done_o      = ~flush_i;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // After a 32-step multiply the product sits in the middle of {hi,lo}.
    assign w_prod   = r_word ? {{XLEN{1'b0}}, r_hi[31:0], r_lo[XLEN-1:32]} : {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_q      = r_word ? {{(XLEN-32){1'b0}}, r_lo[31:0]} : r_lo;
    assign w_r      = r_word ? {{(XLEN-32){1'b0}}, r_hi[31:0]} : r_hi;
    assign w_q_s    = r_neg_q ? -w_q : w_q;
    assign w_r_s    = r_neg_a ? -w_r : w_r;

    always_comb begin
        w_raw = '0;
        if (r_sel[2]) begin
            if (r_dz)
                w_raw = r_sel[1] ? r_src1 : '1;
            else if (r_ovf)
                w_raw = r_sel[1] ? '0 : r_src1;
            else
                w_raw = r_sel[1] ? w_r_s : w_q_s;
        end else if (r_mz) begin
            w_raw = '0;
        end else if (r_sel[1:0] == 2'b00) begin
            w_raw = w_prod_s[XLEN-1:0];
        end else begin
            w_raw = r_word ? {{(XLEN-32){1'b0}}, w_prod_s[63:32]} : w_prod_s[2*XLEN-1:XLEN];
        end
    end

    assign w_final  = r_word ? sext32(w_raw[31:0]) : w_raw;
    assign result_o = (r_state == ST_DONE && !flush_i) ? w_final : r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sel    <= '0;
            r_word   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_a  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_mz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_src1   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= w_cnt_init;
                        r_sel   <= sel_i;
                        r_word  <= word_i;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_a <= w_a_neg;
                        r_dz    <= w_dz;
                        r_ovf   <= w_ovf;
                        r_mz    <= w_mz;
                        r_src1  <= src1_i;
                        r_hi    <= '0;
                        if (sel_i[2]) begin
                            r_lo   <= word_i ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                            r_opnd <= w_b_mag;
                        end else begin
                            r_lo   <= w_b_mag;
                            r_opnd <= w_a_mag;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        r_cnt <= '0;
                    end else begin
                        r_hi  <= w_hi_nxt;
                        r_lo  <= w_lo_nxt;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!flush_i)
                        r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdu_seq : directed vectors with a queue-based result scoreboard.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  sel_i = 3'b000;
    logic        word_i = 1'b0;
    logic [63:0] src1_i = '0;
    logic [63:0] src2_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] last_res = '0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    mdu_seq #(.XLEN(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .sel_i    (sel_i),
        .word_i   (word_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic word, input bit special);
`ifdef MDU_EARLY_OUT_EN
        if (special) return 2;
`endif
        return word ? 33 : 65;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h at cycle %0d, expected no done", result_o, cyc);
            end else begin
                e = sb_q.pop_front();
                check64({e.name, "_result"}, result_o, e.res);
                check_int({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] sel, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input bit special);
        exp_t e;
        bit   busy_ok;
        bit   seen;
        busy_ok = 1'b1;
        seen    = 1'b0;
        @(negedge clk);
        check64({name, "_hold_prev"}, result_o, last_res);
        start_i = 1'b1;
        sel_i   = sel;
        word_i  = word;
        src1_i  = a;
        src2_i  = b;
        e.res   = exp;
        e.cyc   = cyc + lat_of(word, special);
        e.name  = name;
        sb_q.push_back(e);
        #1;
        if (busy_o !== 1'b1) busy_ok = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                if (busy_o !== 1'b0) busy_ok = 1'b0;
            end else if (busy_o !== 1'b1) begin
                busy_ok = 1'b0;
            end
            start_i = 1'b0;
        end
        check_int({name, "_busy_profile"}, int'(busy_ok), 1);
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done_o, expected done within 200 cycles", name);
        end
        last_res = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check64("reset_busy", {63'd0, busy_o}, 64'd0);
        check64("reset_done", {63'd0, done_o}, 64'd0);
        check64("reset_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_3_x_m5", F3_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op("div_m7_2",   F3_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("rem_m7_2",   F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("mulhu_ones", F3_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("mulh_min_2", F3_MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("mulhsu_m1_ones", F3_MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("divu_by0",   F3_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_op("remu_by0",   F3_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1'b1);
        run_op("div_m7_by0", F3_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_op("rem_m7_by0", F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
        run_op("div_ovf",    F3_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1);
        run_op("rem_ovf",    F3_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b1);
        run_op("divu_big",   F3_DIVU, 1'b0, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("remu_big",   F3_REMU, 1'b0, '1, 64'h10, 64'hF, 1'b0);
        run_op("mul_zero",   F3_MUL, 1'b0, 64'h1234, 64'd0, 64'd0, 1'b1);
        run_op("mulw",       F3_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("divuw",      F3_DIVU, 1'b1, 64'hABCD_0000_0000_0010, 64'd2, 64'd8, 1'b0);
        run_op("divw_m7_2",  F3_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h0000_0001_0000_0002,
               64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("divw_ovf",   F3_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1'b1);

        // Flush during CALC in cycle 10; a new request in cycle 12 must be taken.
        @(negedge clk);
        start_i = 1'b1; sel_i = F3_MUL; word_i = 1'b0; src1_i = 64'd5; src2_i = 64'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        check64("flush_busy_before", {63'd0, busy_o}, 64'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check64("flush_busy_after", {63'd0, busy_o}, 64'd0);
        check64("flush_done_after", {63'd0, done_o}, 64'd0);
        check64("flush_result_kept", result_o, last_res);
        run_op("mul_after_flush", F3_MUL, 1'b0, 64'd6, 64'd7, 64'd42, 1'b0);

        // Flush beats start in IDLE.
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; sel_i = F3_MUL; src1_i = 64'd2; src2_i = 64'd2;
        #1;
        check64("idle_flush_busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check64("idle_flush_not_taken", {63'd0, busy_o}, 64'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start_i = 1'b1; sel_i = F3_DIVU; word_i = 1'b0; src1_i = 64'd100; src2_i = 64'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check64("rst_mid_busy", {63'd0, busy_o}, 64'd0);
        check64("rst_mid_done", {63'd0, done_o}, 64'd0);
        check64("rst_mid_result", result_o, 64'd0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("remu_after_rst", F3_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0);

        repeat (5) @(negedge clk);
        check_int("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
